// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the arbiter's requester-side and fifo-side signals.
// slave: the arbiter itself. master: the environment driving requests and fifo flags.
interface fifo_wr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4,
    parameter int B = 8
);
    logic [N-1:0]   req;
    logic [N*B-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           wr;
    logic [B-1:0]   wr_data;
    logic           rd;
    logic           empty;
    logic           full;
    logic [W:0]     level;

    modport slave (
        input  req, req_data, rd, empty, full,
        output gnt, wr, wr_data, level
    );

    modport master (
        output req, req_data, rd, empty, full,
        input  gnt, wr, wr_data, level
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N requesters, with its own occupancy count.
// Optional macro FIFO_ARB_BURST_EN lets a winner keep priority for up to MAX_BURST consecutive grants.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 4,
    parameter int B         = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int LW = $clog2(N);
    localparam logic [W:0] DEPTH_V = {1'b1, {W{1'b0}}};

    if (N < 2 || N > 8 || MAX_BURST < 1) begin : g_bad_param
        $error("fifo_wr_arbiter: N must be 2..8 and MAX_BURST >= 1");
    end

    logic [W:0]    level_reg;
    logic          wr_reg;
    logic [B-1:0]  wr_data_reg;
    logic [LW-1:0] last_winner_reg;

    logic          space;
    logic          rd_eff;
    logic [LW-1:0] next_idx;
    logic [LW-1:0] start_idx;
    logic [LW-1:0] cand_idx [N];
    logic [LW-1:0] gnt_idx;
    logic          gnt_any;
    logic [N-1:0]  gnt_vec;

    // Gated by rst_n so the grant drops the moment reset is asserted.
    assign space    = rst_n && (level_reg < DEPTH_V) && !bus.full;
    assign rd_eff   = bus.rd && !bus.empty;
    assign next_idx = (last_winner_reg == LW'(N - 1)) ? '0 : last_winner_reg + LW'(1);

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt_reg;
    logic          burst_hold;

    // The winner keeps priority while its burst is open and it still requests.
    assign burst_hold = (burst_cnt_reg != '0) && (burst_cnt_reg < BW'(MAX_BURST))
                        && bus.req[last_winner_reg];
    assign start_idx  = burst_hold ? last_winner_reg : next_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_reg <= '0;
        end else if (gnt_any) begin
            burst_cnt_reg <= (burst_hold && gnt_idx == last_winner_reg)
                             ? burst_cnt_reg + BW'(1) : BW'(1);
        end else begin
            burst_cnt_reg <= '0;
        end
    end
`else
    assign start_idx = next_idx;
`endif

    // Candidate k is the k-th requester searching upward from start_idx, modulo N.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [LW:0] sum;
        assign sum          = {1'b0, start_idx} + (LW + 1)'(gi);
        assign cand_idx[gi] = (sum >= (LW + 1)'(N)) ? LW'(sum - (LW + 1)'(N)) : LW'(sum);
    end

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        gnt_vec = '0;
        if (space) begin
            // Walk backwards so the lowest-offset candidate wins.
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.req[cand_idx[k]]) begin
                    gnt_idx = cand_idx[k];
                    gnt_any = 1'b1;
                end
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg          <= 1'b0;
            wr_data_reg     <= '0;
            level_reg       <= '0;
            last_winner_reg <= LW'(N - 1);
        end else begin
            wr_reg <= gnt_any;
            if (gnt_any) begin
                wr_data_reg     <= bus.req_data[gnt_idx*B +: B];
                last_winner_reg <= gnt_idx;
            end
            // The slot is reserved at grant time, one cycle before the fifo sees wr.
            case ({gnt_any, rd_eff})
                2'b10:   level_reg <= level_reg + (W + 1)'(1);
                2'b01:   level_reg <= level_reg - (W + 1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign bus.gnt     = gnt_vec;
    assign bus.wr      = wr_reg;
    assign bus.wr_data = wr_data_reg;
    assign bus.level   = level_reg;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: round-robin model plus a write-data scoreboard.
// Define FIFO_ARB_BURST_EN for both bench and RTL to exercise the burst mode.
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int B = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH = 1 << W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .W(W), .B(B)) bus ();

    fifo_wr_arbiter #(.N(N), .W(W), .B(B), .MAX_BURST(MAX_BURST)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;

    // reference model state
    int m_last = N - 1;
    int m_level = 0;
    int m_cnt = 0;
    bit m_wr = 1'b0;
    logic [B-1:0] sb[$];

    // values seen at the most recent negedge check
    logic [N-1:0] g_obs;
    logic [W:0]   l_obs;
    logic         w_obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_idx(output bit hold);
        int start;
        hold = 1'b0;
        if (m_level >= DEPTH || bus.full) return -1;
        start = (m_last + 1) % N;
`ifdef FIFO_ARB_BURST_EN
        if (m_cnt > 0 && m_cnt < MAX_BURST && bus.req[m_last]) begin
            hold = 1'b1;
            start = m_last;
        end
`endif
        for (int k = 0; k < N; k++) begin
            if (bus.req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_level = 0;
        m_cnt = 0;
        m_wr = 1'b0;
        sb.delete();
    endtask

    // One clock: check outputs at the negedge, advance the model, step past the posedge.
    task automatic cycle();
        int e;
        bit hold;
        bit rd_eff;
        logic [B-1:0] d;
        logic [31:0] eg;
        @(negedge clk);
        l_obs = bus.level;
        w_obs = bus.wr;
        g_obs = bus.gnt;
        chk("level", 32'(bus.level), 32'(m_level));
        chk("wr", 32'(bus.wr), 32'(m_wr));
        if (bus.wr === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                d = sb.pop_front();
                chk("wr_data", 32'(bus.wr_data), 32'(d));
                $display("write data=%02h level=%0d", bus.wr_data, bus.level);
            end
        end
        e = exp_idx(hold);
        eg = (e < 0) ? 32'd0 : (32'd1 << e);
        chk("gnt", 32'(bus.gnt), eg);
        rd_eff = bus.rd && !bus.empty;
        if (e >= 0) begin
            sb.push_back(bus.req_data[e*B +: B]);
            m_cnt = (hold && e == m_last) ? m_cnt + 1 : 1;
            m_last = e;
            m_wr = 1'b1;
            if (!rd_eff) m_level++;
        end else begin
            m_cnt = 0;
            m_wr = 1'b0;
            if (rd_eff) m_level--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef FIFO_ARB_BURST_EN
    int burst_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`endif

    initial begin
        bus.req = '0;
        bus.rd = 1'b0;
        bus.empty = 1'b1;
        bus.full = 1'b0;
        for (int i = 0; i < N; i++) bus.req_data[i*B +: B] = 8'hA0 + 8'(i);

        #2;
        chk("rst_wr", 32'(bus.wr), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        do_reset();

        // fill: grants rotate 0,1,2,3 until level reaches DEPTH
        bus.req = 4'b1111;
        for (int k = 0; k < DEPTH + 2; k++) begin
            cycle();
            if (k < 8) chk("fill_order", 32'(g_obs), 32'd1 << (k % N));
        end
        chk("fill_level", 32'(l_obs), 32'(DEPTH));
        chk("fill_gnt", 32'(g_obs), 32'd0);

        // read at full: no grant on the read edge, grant on the next
        bus.req = 4'b0010;
        bus.rd = 1'b1;
        bus.empty = 1'b0;
        cycle();
        chk("full_rd_gnt", 32'(g_obs), 32'd0);
        bus.rd = 1'b0;
        cycle();
        chk("full_rd_level", 32'(l_obs), 32'(DEPTH - 1));
        chk("full_rd_regnt", 32'(g_obs), 32'b0010);
        bus.req = 4'b0000;
        cycle();
        chk("refill_level", 32'(l_obs), 32'(DEPTH));

        // drain to 5, then read and grant together
        bus.rd = 1'b1;
        repeat (DEPTH - 5) cycle();
        bus.req = 4'b0001;
        cycle();
        chk("both_level_pre", 32'(l_obs), 32'd5);
        bus.req = 4'b0000;
        bus.rd = 1'b0;
        cycle();
        chk("both_level", 32'(l_obs), 32'd5);
        chk("both_wr", 32'(w_obs), 32'd1);

`ifndef FIFO_ARB_BURST_EN
        // last_winner = 0: requester 3 goes before 0, then 0 repeats alone
        bus.req = 4'b1001;
        cycle();
        chk("rr_first", 32'(g_obs), 32'b1000);
        cycle();
        chk("rr_second", 32'(g_obs), 32'b0001);
        bus.req = 4'b0001;
        cycle();
        chk("solo_a", 32'(g_obs), 32'b0001);
        cycle();
        chk("solo_b", 32'(g_obs), 32'b0001);
`else
        do_reset();
        bus.req = 4'b0011;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("burst_order", 32'(g_obs), 32'd1 << burst_seq[k]);
        end
        cycle();
        chk("burst_beat2", 32'(g_obs), 32'b0001);
        bus.req = 4'b0010;
        cycle();
        chk("burst_drop", 32'(g_obs), 32'b0010);
`endif

        // random traffic with occasional full
        bus.req = '0;
        for (int k = 0; k < 300; k++) begin
            bus.req = 4'($urandom_range(0, 15));
            bus.rd = 1'($urandom_range(0, 1));
            bus.full = ($urandom_range(0, 7) == 0);
            bus.empty = (m_level == 0);
            cycle();
        end
        bus.rd = 1'b0;
        bus.full = 1'b0;
        bus.empty = 1'b1;

        // asynchronous reset while a write is in flight at level 9
        do_reset();
        bus.req = 4'b1111;
        repeat (9) cycle();
        chk("pre_rst_wr", 32'(bus.wr), 32'd1);
        chk("pre_rst_level", 32'(bus.level), 32'd9);
        rst_n = 1'b0;
        #1;
        chk("async_wr", 32'(bus.wr), 32'd0);
        chk("async_level", 32'(bus.level), 32'd0);
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        chk("post_rst_gnt", 32'(g_obs), 32'b0001);
        bus.req = '0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo write port (wr/wr_data) between N requesters.
- Keeps its own occupancy count from granted writes and observed reads, so it never issues a write into a full fifo, even with its one-cycle registered write pipeline.
- Sits directly in front of fifo; its wr, wr_data, rd and empty connections map one-to-one onto the fifo ports.

Parameters:
N, 4, number of write requesters (2..8)
W, 4, fifo address bits; depth DEPTH = 2**W
B, 8, data width in bits
MAX_BURST, 4, maximum consecutive grants to one requester; used only when FIFO_ARB_BURST_EN is defined

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  per-requester write request; hold req and data stable until granted
req_data  input  N*B  flattened request data; requester i uses bits [i*B +: B]
gnt  output  N  combinational one-hot grant; data of requester i is consumed on the clk edge where gnt[i]=1
wr  output  1  registered write strobe to fifo
wr_data  output  B  registered write data to fifo
rd  input  1  fifo read strobe, observed only
empty  input  1  fifo empty flag
full  input  1  fifo full flag, used as a safety gate
level  output  W+1  registered occupancy count, 0..DEPTH

Behaviour:
- Reset (async, rst_n=0):
  - wr=0, wr_data=0, level=0.
  - Last-winner pointer = N-1, so requester 0 has priority first.
  - Burst counter = 0.
- Space condition: space = (level < DEPTH) && !full.
- Grant (combinational):
  - If space is true and req is nonzero, gnt = the first set req bit searching upward (modulo N) from last_winner+1.
  - Otherwise gnt = 0.
  - Exactly zero or one gnt bit is ever set.
- Write pipeline, on the edge with gnt[i]=1:
  - wr <= 1; wr_data <= req_data[i*B +: B]; last_winner <= i.
  - Otherwise wr <= 0 and wr_data holds its value.
  - Latency from grant to fifo write: 1 cycle.
- Read detection: rd_eff = rd && !empty.
- Level update each edge:
  - +1 when a grant occurs and rd_eff=0.
  - -1 when rd_eff=1 and no grant.
  - Unchanged when both or neither occur.
  - Level counts a write at grant time, so the write still in flight is already reserved.
- Level limits:
  - level never exceeds DEPTH.
  - When level == DEPTH, no grant is issued, even if rd_eff=1 in the same cycle. The freed slot is granted the next cycle.
- Read while level == 0 is impossible (empty=1 masks it); level never goes below 0.
- Requester dropping req without a grant: allowed; no side effects.
- Requester changing req_data while req=1 and not granted: undefined data, not checked.
- Reset asserted mid-operation:
  - All state clears immediately.
  - An in-flight wr is cancelled (wr forced to 0).
  - fifo must be reset together with this block.

Optional Feature:
Macro FIFO_ARB_BURST_EN.
- Defined:
  - A burst counter runs while the current winner keeps req asserted and keeps receiving grants.
  - The current winner keeps priority until it has received MAX_BURST consecutive grants. Arbitration then resumes from winner+1 and the counter resets.
  - A gap in the winner's req, or a cycle with no space, also ends the burst.
- Not defined: last_winner advances after every grant (pure single-beat round robin); no burst counter logic.

Test Plan:
- Reset, then req=4'b1111 held with distinct data 0xA0..0xA3 per requester, no reads.
  - Without burst: gnt order 0,1,2,3,0,...
  - wr follows each gnt by 1 cycle.
  - 16 grants total, then gnt=0 and level=16.
- Fill to level=16, then pulse rd for 1 cycle with req=4'b0010.
  - level goes 16→15 on the read edge.
  - gnt[1]=1 on the next cycle; level returns to 16.
- level=5, rd_eff and a grant in the same cycle: level stays at 5 and wr=1 one cycle later.
- req=4'b1001 after last_winner=0: gnt[3] before gnt[0]. After that, req=4'b0001 only: gnt[0] on consecutive cycles.
- FIFO_ARB_BURST_EN with MAX_BURST=4, req=4'b0011 held:
  - Grants go 0,0,0,0,1,1,1,1,0.
  - Dropping req[0] after 2 beats hands the grant to 1 immediately.
- Assert rst_n=0 while wr=1 and level=9: wr=0, level=0 and gnt=0 asynchronously. After release, the first grant goes to requester 0.
